// File: rtl/id_inst_queue_if.sv
// Fetch-to-decode instruction queue bus: fetch push side, decode pop side,
// flush, and status back to the PC stage.
interface id_inst_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_ready;
  logic              afull;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;
  logic [CW-1:0]     count;

  // Pipeline side: fetch pushes, decode pops, branch unit flushes.
  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, afull, out_valid, out_pc, out_inst, count
  );

  // Queue side.
  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, afull, out_valid, out_pc, out_inst, count
  );
endinterface

// File: rtl/id_inst_queue.sv
// First-word-fall-through {pc, inst} queue between IF and decode. The head
// is presented straight from storage; an empty queue presents a NOP.
module id_inst_queue #(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter int INST_W    = 32,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic            clk,
  input  logic            rst,
  id_inst_queue_if.slave  q_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("id_inst_queue: DEPTH must be a power of two >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("id_inst_queue: AFULL_LVL must be in 1..DEPTH");
  end

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_rdy, out_vld, push, pop;
  entry_t        head;

  // Handshake qualifiers: ready/valid come only from registered count, so
  // a full queue refuses a push even when decode pops in the same cycle.
  always_comb begin
    in_rdy  = (count_q < CW'(DEPTH));
    out_vld = (count_q != '0);
    push    = q_if.in_valid & in_rdy  & ~q_if.flush;
    pop     = q_if.out_ready & out_vld & ~q_if.flush;
  end

  // Next pointer/occupancy state; flush discards everything and re-zeroes
  // the pointers so the next push lands in slot 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer/occupancy registers; reset beats flush, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= '{pc: q_if.in_pc, inst: q_if.in_inst};
  end

  // Head presentation: fall-through from storage, NOP when empty.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    q_if.in_ready  = in_rdy;
    q_if.afull     = (count_q >= CW'(AFULL_LVL));
    q_if.out_valid = out_vld;
    q_if.out_pc    = out_vld ? head.pc   : '0;
    q_if.out_inst  = out_vld ? head.inst : '0;
    q_if.count     = count_q;
  end
endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue: directed scenarios plus random traffic against
// a queue-based reference model.
module tb_id_inst_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int INST_W = 32;
  localparam int AFULL = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OW    = 3 + CW + PC_W + INST_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_inst_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) qif ();

  id_inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .AFULL_LVL(AFULL)) dut (
    .clk  (clk),
    .rst  (rst),
    .q_if (qif)
  );

  int errs   = 0;
  int checks = 0;
  logic [PC_W+INST_W-1:0] mq [$];

  // Observed status/head word: {in_ready, afull, out_valid, count, pc, inst}.
  wire [OW-1:0] obs = {qif.in_ready, qif.afull, qif.out_valid, qif.count, qif.out_pc, qif.out_inst};
  localparam logic [OW-1:0] RST_OBS = {1'b1, {(OW-1){1'b0}}};

  function automatic logic [OW-1:0] expv();
    int n = mq.size();
    logic [PC_W+INST_W-1:0] hd = (n != 0) ? mq[0] : '0;
    return {1'(n < DEPTH), 1'(n >= AFULL), 1'(n != 0), CW'(n), hd};
  endfunction

  function automatic logic [INST_W-1:0] mk_inst(input logic [PC_W-1:0] pc);
    return pc ^ 32'hA5A5_0F0F;
  endfunction

  task automatic drv(input logic v, input logic [PC_W-1:0] pc, input logic rdy, input logic fl);
    qif.in_valid  = v;
    qif.in_pc     = pc;
    qif.in_inst   = mk_inst(pc);
    qif.out_ready = rdy;
    qif.flush     = fl;
  endtask

  // One clock: model applies the rules to the inputs present at the edge.
  task automatic cyc();
    bit ps, pp;
    @(posedge clk);
    if (rst || qif.flush) mq.delete();
    else begin
      ps = qif.in_valid && (mq.size() < DEPTH);
      pp = qif.out_ready && (mq.size() > 0);
      if (pp) void'(mq.pop_front());
      if (ps) mq.push_back({qif.in_pc, qif.in_inst});
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; drv(0, '0, 0, 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (obs !== RST_OBS) begin errs++; $display("FAIL reset_idle got=%h want=%h", obs, RST_OBS); end
  endtask

  task automatic test_single_hold();
    drv(1, 32'hBFC0_0000, 0, 0);
    qif.in_inst = 32'h3C08_8000;
    cyc();
    drv(0, '0, 0, 0);
    checks++;
    if (qif.out_valid !== 1'b1 || qif.out_pc !== 32'hBFC0_0000 || qif.out_inst !== 32'h3C08_8000 || qif.count !== CW'(1)) begin
      errs++; $display("FAIL single_push got v=%b pc=%h inst=%h cnt=%0d want v=1 pc=bfc00000 inst=3c088000 cnt=1",
                       qif.out_valid, qif.out_pc, qif.out_inst, qif.count);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (obs !== expv() || qif.out_inst !== 32'h3C08_8000) begin
        errs++; $display("FAIL hold_stall[%0d] got=%h want=%h", i, obs, expv());
      end
    end
    drv(0, '0, 0, 1); cyc(); drv(0, '0, 0, 0);
  endtask

  task automatic test_fill_order();
    logic [PC_W-1:0] got;
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'(4 * i), 0, 0);
      cyc();
      checks++;
      if (obs !== expv()) begin errs++; $display("FAIL fill[%0d] got=%h want=%h", i, obs, expv()); end
      if (i == 2) begin
        checks++;
        if (qif.afull !== 1'b1 || qif.in_ready !== 1'b1) begin
          errs++; $display("FAIL afull_at3 got afull=%b rdy=%b want afull=1 rdy=1", qif.afull, qif.in_ready);
        end
      end
    end
    checks++;
    if (qif.in_ready !== 1'b0 || qif.count !== CW'(4)) begin
      errs++; $display("FAIL full got rdy=%b cnt=%0d want rdy=0 cnt=4", qif.in_ready, qif.count);
    end
    drv(1, 32'h10, 0, 0);
    cyc();
    checks++;
    if (qif.count !== CW'(4) || qif.out_pc !== 32'h0) begin
      errs++; $display("FAIL drop_when_full got cnt=%0d pc=%h want cnt=4 pc=0", qif.count, qif.out_pc);
    end
    // Push attempted while popping a full queue must still be refused.
    for (int i = 0; i < 4; i++) begin
      drv(i == 0, 32'h14, 1, 0);
      got = qif.out_pc;
      checks++;
      if (got !== 32'(4 * i) || qif.out_inst !== mk_inst(32'(4 * i))) begin
        errs++; $display("FAIL pop_order[%0d] got=%h want=%h", i, got, 32'(4 * i));
      end
      cyc();
    end
    drv(0, '0, 0, 0);
    checks++;
    if (obs !== RST_OBS) begin errs++; $display("FAIL drained got=%h want=%h", obs, RST_OBS); end
  endtask

  task automatic test_stream();
    drv(1, 32'h0, 1, 0);
    cyc();
    for (int i = 1; i < 10; i++) begin
      drv(1, 32'(4 * i), 1, 0);
      checks++;
      if (qif.count !== CW'(1) || qif.out_pc !== 32'(4 * (i - 1)) || qif.out_inst !== mk_inst(32'(4 * (i - 1)))) begin
        errs++; $display("FAIL stream[%0d] got cnt=%0d pc=%h want cnt=1 pc=%h", i, qif.count, qif.out_pc, 32'(4 * (i - 1)));
      end
      cyc();
    end
    drv(0, '0, 1, 0);
    checks++;
    if (qif.out_pc !== 32'h24) begin errs++; $display("FAIL stream_last got=%h want=00000024", qif.out_pc); end
    cyc();
    drv(0, '0, 0, 0);
    checks++;
    if (obs !== RST_OBS) begin errs++; $display("FAIL stream_drain got=%h want=%h", obs, RST_OBS); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin drv(1, 32'(32'h40 + 4 * i), 0, 0); cyc(); end
    drv(1, 32'h60, 1, 1);
    cyc();
    drv(0, '0, 0, 0);
    checks++;
    if (qif.count !== '0 || qif.out_valid !== 1'b0 || qif.out_inst !== '0) begin
      errs++; $display("FAIL flush got cnt=%0d v=%b inst=%h want 0 0 0", qif.count, qif.out_valid, qif.out_inst);
    end
    drv(1, 32'h80, 0, 0);
    cyc();
    drv(0, '0, 0, 0);
    checks++;
    if (qif.out_pc !== 32'h80 || qif.count !== CW'(1)) begin
      errs++; $display("FAIL post_flush got pc=%h cnt=%0d want pc=80 cnt=1", qif.out_pc, qif.count);
    end
    drv(0, '0, 0, 1); cyc(); drv(0, '0, 0, 0);
  endtask

  task automatic test_reset_mid();
    drv(1, 32'hC0, 0, 0); cyc();
    drv(1, 32'hC4, 0, 0); cyc();
    rst = 1'b1; drv(1, 32'hC8, 1, 1);
    cyc();
    rst = 1'b0; drv(0, '0, 0, 0);
    checks++;
    if (obs !== RST_OBS) begin errs++; $display("FAIL reset_mid got=%h want=%h", obs, RST_OBS); end
    drv(1, 32'h100, 0, 0); cyc(); drv(0, '0, 0, 0);
    checks++;
    if (qif.out_pc !== 32'h100 || qif.count !== CW'(1)) begin
      errs++; $display("FAIL post_reset got pc=%h cnt=%0d want pc=100 cnt=1", qif.out_pc, qif.count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drv(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
      rst = 1'($urandom_range(0, 99) == 0);
      cyc();
      checks++;
      if (obs !== expv()) begin errs++; $display("FAIL random[%0d] got=%h want=%h", i, obs, expv()); end
    end
    rst = 1'b0; drv(0, '0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_fill_order();
    test_stream();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised instruction queue between the IF stage and the decode stage.
- Replaces the one-entry hold buffer in decode with a DEPTH-entry first-word-fall-through FIFO of {pc, inst} pairs.
- Decode keeps receiving the correct instruction across multi-cycle stalls without re-fetching.
- Supports branch flush, occupancy reporting, an almost-full back-pressure signal to the PC stage, and NOP insertion whenever no valid entry is presented.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PC_W, 32, program-counter width.
- INST_W, 32, instruction width.
- AFULL_LVL, DEPTH-1, occupancy at or above which afull asserts; range 1..DEPTH.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  branch or redirect taken; discards all queued entries.
- in_valid  input  1  fetch response valid (the registered ce from IF).
- in_pc  input  PC_W  PC of the fetched instruction.
- in_inst  input  INST_W  instruction word (inst_sram_rdata).
- in_ready  output  1  queue can accept a push this cycle.
- afull  output  1  occupancy >= AFULL_LVL; used to stall the PC stage.
- out_valid  output  1  head entry valid.
- out_pc  output  PC_W  PC of the head entry.
- out_inst  output  INST_W  instruction of the head entry; all-zero (NOP) when out_valid=0.
- out_ready  input  1  decode consumes the head entry (decode not stalled).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. This gives count=0, out_valid=0, out_pc=0, out_inst=0, afull=0. Pointers cleared. Storage contents need not be reset.
- Push: occurs when in_valid & in_ready & ~flush. The entry is written at wr_ptr; wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Pop: occurs when out_valid & out_ready & ~flush. rd_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH). It is purely a function of registered state, with no combinational path from out_ready. A push into a full queue is therefore never accepted, even if a pop happens in the same cycle.
- Latency: a pushed entry appears on out_* on the cycle after the push (registered FIFO, 1-cycle latency).
- First-word fall-through: out_* always reflect the current head. No read-request cycle is needed.
- out_valid = (count != 0).
- out_pc and out_inst are forced to 0 when count == 0, so decode sees a NOP.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Simultaneous push and pop at count == 0: only the push occurs, because out_valid=0. count becomes 1.
- Flush has priority over push and pop. On the next cycle count=0, rd_ptr=wr_ptr=0, out_valid=0, out_inst=0. A push in the flush cycle is dropped, and so is a pop.
- afull = (count >= AFULL_LVL), evaluated on registered count.
- Held stall: with out_ready=0 for N cycles, out_pc and out_inst stay stable and bit-exact for all N cycles.
- Wrap-around: an entry that lands in slot DEPTH-1 is followed by an entry in slot 0. Order is preserved (FIFO).
- Reset asserted mid-operation: it overrides flush, push and pop, and produces the reset state on the next edge.
- in_valid while in_ready=0: the data is lost, and the queue asserts nothing. The upstream must gate fetch with afull or in_ready.
- Arithmetic: count is updated as count + push - pop in $clog2(DEPTH)+1 bits and never exceeds DEPTH.

Test Plan:
1. Reset, then idle: count=0, out_valid=0, out_inst=32'h0, in_ready=1, afull=0.
2. Push pc=0xBFC00000/inst=0x3C088000 with out_ready=0. Next cycle: out_valid=1, out_pc=0xBFC00000, out_inst=0x3C088000, count=1. Held stable over 5 stall cycles.
3. Fill DEPTH=4 with pcs 0x0, 0x4, 0x8, 0xC and out_ready=0: afull=1 at count=3, in_ready=0 at count=4. A fifth push of pc 0x10 is dropped. Popping 4 entries yields 0x0, 0x4, 0x8, 0xC in order.
4. Streaming with push and pop every cycle over 10 instructions (pcs 0x0..0x24): count stays at 1 and pointers wrap twice. Output sequence equals input sequence delayed by 1 cycle.
5. count=3 with flush=1, in_valid=1 and out_ready=1 in the same cycle: next cycle count=0, out_valid=0, out_inst=0. A subsequent push of pc 0x80 appears as the head.
6. rst asserted while count=2 and push and pop are active: next cycle shows the reset state. A push of pc 0x100 after reset appears first.
